// File: rtl/l1_cache_pkg.sv
// Shared types and geometry for the direct-mapped write-back L1 cache.
package l1_cache_pkg;
  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

  localparam int WORDS_PER_BLOCK = 4;
  localparam int WORD_W          = 32;
  localparam int BLOCK_W         = 128;
  localparam int MEM_ADDR_W      = 28;
  localparam int PROC_ADDR_W     = 30;

  // Block address is {tag, index}, so the tag keeps whatever the index does not.
  function automatic int tag_w(input int index_w);
    return MEM_ADDR_W - index_w;
  endfunction
endpackage

// File: rtl/l1_cache_if.sv
// CPU-side word port and memory-side block port of the L1 cache.
interface l1_proc_if;
  import l1_cache_pkg::*;
  logic                   proc_read;
  logic                   proc_write;
  logic [PROC_ADDR_W-1:0] proc_addr;
  logic [WORD_W-1:0]      proc_wdata;
  logic                   proc_stall;
  logic [WORD_W-1:0]      proc_rdata;

  modport master (output proc_read, proc_write, proc_addr, proc_wdata,
                  input  proc_stall, proc_rdata);
  modport slave  (input  proc_read, proc_write, proc_addr, proc_wdata,
                  output proc_stall, proc_rdata);
endinterface

interface l1_mem_if;
  import l1_cache_pkg::*;
  logic                  mem_read;
  logic                  mem_write;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic [BLOCK_W-1:0]    mem_wdata;
  logic [BLOCK_W-1:0]    mem_rdata;
  logic                  mem_ready;

  modport master (output mem_read, mem_write, mem_addr, mem_wdata,
                  input  mem_rdata, mem_ready);
  modport slave  (input  mem_read, mem_write, mem_addr, mem_wdata,
                  output mem_rdata, mem_ready);
endinterface

// File: rtl/l1_cache_array.sv
// Tag/valid/dirty/data storage: one combinational read port, one write port (word write or line fill).
module l1_cache_array
  import l1_cache_pkg::*;
#(
  parameter int NUM_BLOCKS = 8,
  parameter int INDEX_W    = $clog2(NUM_BLOCKS),
  parameter int TAG_W      = tag_w(INDEX_W)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INDEX_W-1:0] i_idx,
  input  logic               i_word_we,
  input  logic [1:0]         i_word_off,
  input  logic [WORD_W-1:0]  i_word_data,
  input  logic               i_fill_we,
  input  logic [TAG_W-1:0]   i_fill_tag,
  input  logic [BLOCK_W-1:0] i_fill_data,
  output logic               o_valid,
  output logic               o_dirty,
  output logic [TAG_W-1:0]   o_tag,
  output logic [BLOCK_W-1:0] o_data
);
  logic [NUM_BLOCKS-1:0] r_valid;
  logic [NUM_BLOCKS-1:0] r_dirty;
  logic [TAG_W-1:0]      r_tag  [NUM_BLOCKS];
  logic [BLOCK_W-1:0]    r_data [NUM_BLOCKS];

  assign o_valid = r_valid[i_idx];
  assign o_dirty = r_dirty[i_idx];
  assign o_tag   = r_tag[i_idx];
  assign o_data  = r_data[i_idx];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_fill_we) begin
      r_valid[i_idx] <= 1'b1;
      r_dirty[i_idx] <= 1'b0;
    end else if (i_word_we) begin
      r_dirty[i_idx] <= 1'b1;
    end
  end

  // Payload arrays carry no reset; valid bits guard them.
  always_ff @(posedge clk) begin
    if (i_fill_we) begin
      r_tag[i_idx]  <= i_fill_tag;
      r_data[i_idx] <= i_fill_data;
    end else if (i_word_we) begin
      r_data[i_idx][i_word_off*WORD_W +: WORD_W] <= i_word_data;
    end
  end
endmodule

// File: rtl/l1_cache.sv
// Direct-mapped write-back, write-allocate L1 cache: hit logic and miss FSM around l1_cache_array.
module l1_cache
  import l1_cache_pkg::*;
#(
  parameter int NUM_BLOCKS = 8,
  parameter int INDEX_W    = $clog2(NUM_BLOCKS)
) (
  input  logic      clk,
  input  logic      rst_n,
  l1_proc_if.slave  proc,
  l1_mem_if.master  mem
);
  localparam int TAG_W = tag_w(INDEX_W);

  state_t                r_state, w_next;
  logic [MEM_ADDR_W-1:0] r_miss_blk;
  logic [INDEX_W-1:0]    w_req_idx, w_arr_idx;
  logic [TAG_W-1:0]      w_req_tag, w_arr_tag;
  logic [1:0]            w_off;
  logic                  w_req, w_hit, w_miss, w_arr_valid, w_arr_dirty;
  logic                  w_word_we, w_fill_we, w_rd_hit;
  logic [BLOCK_W-1:0]    w_arr_data;

  assign w_req     = proc.proc_read | proc.proc_write;
  assign w_off     = proc.proc_addr[1:0];
  assign w_req_idx = proc.proc_addr[INDEX_W+1:2];
  assign w_req_tag = proc.proc_addr[PROC_ADDR_W-1:INDEX_W+2];
  // While a miss is outstanding the array looks at the latched line, so a dropped
  // or changed CPU request cannot redirect the writeback or the fill.
  assign w_arr_idx = (r_state == IDLE) ? w_req_idx : r_miss_blk[INDEX_W-1:0];
  assign w_hit     = w_arr_valid && (w_arr_tag == w_req_tag);
  assign w_miss    = w_req && !w_hit;

  assign w_word_we = (r_state == IDLE) && proc.proc_write && w_hit;
  assign w_fill_we = (r_state == ALLOCATE) && mem.mem_ready;
  assign w_rd_hit  = (r_state == IDLE) && proc.proc_read && !proc.proc_write && w_hit;

  assign proc.proc_stall = w_req && ((r_state != IDLE) || !w_hit);
  assign proc.proc_rdata = w_rd_hit ? w_arr_data[w_off*WORD_W +: WORD_W] : '0;

  l1_cache_array #(
    .NUM_BLOCKS (NUM_BLOCKS),
    .INDEX_W    (INDEX_W),
    .TAG_W      (TAG_W)
  ) u_array (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_idx       (w_arr_idx),
    .i_word_we   (w_word_we),
    .i_word_off  (w_off),
    .i_word_data (proc.proc_wdata),
    .i_fill_we   (w_fill_we),
    .i_fill_tag  (r_miss_blk[MEM_ADDR_W-1:INDEX_W]),
    .i_fill_data (mem.mem_rdata),
    .o_valid     (w_arr_valid),
    .o_dirty     (w_arr_dirty),
    .o_tag       (w_arr_tag),
    .o_data      (w_arr_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_miss_blk <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_miss) r_miss_blk <= proc.proc_addr[PROC_ADDR_W-1:2];
    end
  end

  always_comb begin
    w_next        = r_state;
    mem.mem_read  = 1'b0;
    mem.mem_write = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    case (r_state)
      IDLE: begin
        if (w_miss) w_next = (w_arr_valid && w_arr_dirty) ? WRITEBACK : ALLOCATE;
      end
      WRITEBACK: begin
        mem.mem_write = 1'b1;
        mem.mem_addr  = {w_arr_tag, r_miss_blk[INDEX_W-1:0]};
        mem.mem_wdata = w_arr_data;
        if (mem.mem_ready) w_next = ALLOCATE;
      end
      ALLOCATE: begin
        mem.mem_read = 1'b1;
        mem.mem_addr = r_miss_blk;
        if (mem.mem_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  ap_rw_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(proc.proc_read && proc.proc_write));
  ap_mem_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(mem.mem_read && mem.mem_write));
endmodule

// File: tb/tb_l1_cache.sv
// Directed and random checks of l1_cache against a word-level reference and a latency-programmable memory.
module tb_l1_cache;
  logic clk;
  logic rst_n;
  int   lat;
  int   n_tests;
  int   n_fail;

  logic [127:0] mem_model [logic [27:0]];
  logic [31:0]  refw      [logic [29:0]];
  logic [31:0]  sb_q [$];

  l1_proc_if pif ();
  l1_mem_if  mif ();

  l1_cache #(.NUM_BLOCKS(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .proc  (pif.slave),
    .mem   (mif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] init_blk(input logic [27:0] b);
    logic [127:0] v;
    for (int w = 0; w < 4; w++) v[w*32 +: 32] = 32'hC000_0000 | {2'b00, b, 2'b00} | 32'(w);
    return v;
  endfunction

  function automatic logic [127:0] backing(input logic [27:0] b);
    if (mem_model.exists(b)) return mem_model[b];
    return init_blk(b);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [29:0] a);
    logic [127:0] blk;
    if (refw.exists(a)) return refw[a];
    blk = backing(a[29:2]);
    return blk[a[1:0]*32 +: 32];
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory answers on the lat-th cycle of each request; writebacks land in mem_model.
  initial begin
    int cnt;
    cnt = 0;
    mif.mem_ready = 1'b0;
    mif.mem_rdata = '0;
    forever begin
      @(negedge clk);
      mif.mem_ready = 1'b0;
      if (!rst_n || !(mif.mem_read || mif.mem_write)) cnt = 0;
      else begin
        cnt++;
        if (cnt >= lat) begin
          cnt = 0;
          mif.mem_ready = 1'b1;
          if (mif.mem_read) mif.mem_rdata = backing(mif.mem_addr);
          else mem_model[mif.mem_addr] = mif.mem_wdata;
        end
      end
    end
  end

  task automatic access(input bit wr, input logic [29:0] a, input logic [31:0] d,
                        output int st, output int nrd, output int nwr,
                        output logic [27:0] wb_a, output logic [127:0] wb_d,
                        output logic [27:0] al_a);
    logic [31:0] exp;
    bit done, tmo;
    st = 0; nrd = 0; nwr = 0; wb_a = '0; wb_d = '0; al_a = '0;
    done = 0; tmo = 0;
    pif.proc_read  = !wr;
    pif.proc_write = wr;
    pif.proc_addr  = a;
    pif.proc_wdata = d;
    if (!wr) sb_q.push_back(ref_rd(a));
    while (!done) begin
      @(negedge clk);
      chk("mem_excl", 128'(mif.mem_read & mif.mem_write), 128'd0);
      if (mif.mem_read)  begin nrd++; al_a = mif.mem_addr; end
      if (mif.mem_write) begin nwr++; wb_a = mif.mem_addr; wb_d = mif.mem_wdata; end
      if (!pif.proc_stall) done = 1;
      else begin
        st++;
        if (st > 200) begin
          chk("stall_timeout", 128'(pif.proc_stall), 128'd0);
          tmo = 1; done = 1;
        end
      end
    end
    if (!wr) begin
      exp = sb_q.pop_front();
      if (!tmo) chk("rdata", 128'(pif.proc_rdata), 128'(exp));
    end else if (!tmo) begin
      chk("wr_rdata_zero", 128'(pif.proc_rdata), 128'd0);
      refw[a] = d;
    end
    @(posedge clk);
    #1;
    pif.proc_read  = 1'b0;
    pif.proc_write = 1'b0;
  endtask

  initial begin
    int st, nrd, nwr;
    logic [27:0]  wb_a, al_a;
    logic [127:0] wb_d, blk;
    logic [29:0]  a;
    bit           wr;
    n_tests = 0; n_fail = 0; lat = 3;
    rst_n = 1'b0;
    pif.proc_read = 1'b0; pif.proc_write = 1'b0; pif.proc_addr = '0; pif.proc_wdata = '0;
    blk = init_blk(28'h1);
    blk[63:32] = 32'hDEADBEEF;
    mem_model[28'h1] = blk;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_stall",  128'(pif.proc_stall), 128'd0);
    chk("rst_rdata",  128'(pif.proc_rdata), 128'd0);
    chk("rst_mrd",    128'(mif.mem_read),   128'd0);
    chk("rst_mwr",    128'(mif.mem_write),  128'd0);
    chk("rst_maddr",  128'(mif.mem_addr),   128'd0);
    chk("rst_mwdata", mif.mem_wdata,        128'd0);
    @(posedge clk); #1;

    // Cold read miss, memory answers on the 3rd cycle.
    lat = 3;
    access(0, 30'h5, 32'h0, st, nrd, nwr, wb_a, wb_d, al_a);
    chk("cold_nrd",   128'(nrd),  128'd3);
    chk("cold_maddr", 128'(al_a), 128'h1);
    chk("cold_stall", 128'(st),   128'd4);
    chk("cold_nwr",   128'(nwr),  128'd0);

    access(0, 30'h6, 32'h0, st, nrd, nwr, wb_a, wb_d, al_a);
    chk("hit_stall", 128'(st), 128'd0);

    access(1, 30'h4, 32'h12345678, st, nrd, nwr, wb_a, wb_d, al_a);
    chk("whit_stall", 128'(st), 128'd0);

    // Dirty eviction: same index, different tag.
    lat = 2;
    access(0, 30'h24, 32'h0, st, nrd, nwr, wb_a, wb_d, al_a);
    chk("evict_nwr",   128'(nwr),          128'd2);
    chk("evict_wbadr", 128'(wb_a),         128'h1);
    chk("evict_wbw0",  128'(wb_d[31:0]),   128'h12345678);
    chk("evict_wbw1",  128'(wb_d[63:32]),  128'hDEADBEEF);
    chk("evict_aladr", 128'(al_a),         128'h9);
    chk("evict_stall", 128'(st),           128'd5);

    // Write miss to a clean valid line.
    access(0, 30'h8, 32'h0, st, nrd, nwr, wb_a, wb_d, al_a);
    chk("clean_fill_stall", 128'(st), 128'd3);
    access(1, 30'h49, 32'hCAFEF00D, st, nrd, nwr, wb_a, wb_d, al_a);
    chk("wmiss_nwr",   128'(nwr),  128'd0);
    chk("wmiss_nrd",   128'(nrd),  128'd2);
    chk("wmiss_aladr", 128'(al_a), 128'h12);
    chk("wmiss_stall", 128'(st),   128'd3);
    for (int i = 0; i < 4; i++) begin
      a = 30'h48 + 30'(i);
      access(0, a, 32'h0, st, nrd, nwr, wb_a, wb_d, al_a);
      chk("wmiss_rd_stall", 128'(st), 128'd0);
    end

    // Reset in the middle of ALLOCATE.
    lat = 20;
    pif.proc_read = 1'b1; pif.proc_addr = 30'h104;
    @(negedge clk);
    chk("rstm_stall0", 128'(pif.proc_stall), 128'd1);
    @(negedge clk);
    chk("rstm_mrd_pre", 128'(mif.mem_read), 128'd1);
    @(posedge clk); #1;
    rst_n = 1'b0; pif.proc_read = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstm_mrd",   128'(mif.mem_read),   128'd0);
    chk("rstm_stall", 128'(pif.proc_stall), 128'd0);
    refw.delete();
    @(posedge clk); #1;
    lat = 2;
    access(0, 30'h5, 32'h0, st, nrd, nwr, wb_a, wb_d, al_a);
    chk("rstm_reread_st",  128'(st),  128'd3);
    chk("rstm_reread_nrd", 128'(nrd), 128'd2);

    // Random traffic against the reference.
    for (int i = 0; i < 300; i++) begin
      lat = $urandom_range(1, 3);
      a   = 30'($urandom_range(0, 127));
      wr  = 1'($urandom_range(0, 1));
      access(wr, a, $urandom, st, nrd, nwr, wb_a, wb_d, al_a);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/l1_cache.md
# l1_cache

Direct-mapped, write-back, write-allocate L1 cache that answers the CPU pipeline's instruction or data cache port. It takes word-granular `ren`/`wen` requests and holds `stall` high until each request can complete. On the far side it fills and evicts 128-bit blocks to a slow main memory using a level request / `mem_ready` handshake. The block is instantiated twice in the top level, once as I-cache (writes never issued) and once as D-cache. Data passes through unmodified; byte-lane swapping stays in the CPU.

## Interface
- `NUM_BLOCKS`, 8: number of cache lines; power of two ≥ 2.
- `INDEX_W`, $clog2(NUM_BLOCKS): index field width.
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low. Clock is `clk`.
- `proc_read` in 1: word read request; held by the CPU while `proc_stall` is high.
- `proc_write` in 1: word write request; held while `proc_stall` is high.
- `proc_addr` in 30: word address. [1:0] is the word-in-block offset, [INDEX_W+1:2] is the index, the rest is the tag.
- `proc_wdata` in 32: write data.
- `proc_stall` out 1: request cannot complete this cycle.
- `proc_rdata` out 32: read data, valid in a cycle with `proc_read` high and `proc_stall` low.
- `mem_read` out 1: block fill request.
- `mem_write` out 1: block writeback request.
- `mem_addr` out 28: block address, equal to {tag, index}.
- `mem_wdata` out 128: victim block. Word 0 sits in [31:0].
- `mem_rdata` in 128: fill data, sampled when `mem_ready` is high.
- `mem_ready` in 1: one-cycle completion pulse for the current `mem_read` or `mem_write`.

## Operation
- Per line the cache holds `valid`, `dirty`, tag (28−INDEX_W bits) and 4×32 data words.
- Hit condition: `valid[idx]` is set and the stored tag equals the address tag.
- FSM states:
  - IDLE/COMPARE: serves hits.
  - WRITEBACK: `mem_write`=1, `mem_addr` = {victim tag, idx}, `mem_wdata` = victim block.
  - ALLOCATE: `mem_read`=1, `mem_addr` = {req tag, idx}.
- Transitions:
  - IDLE, request miss, victim valid and dirty → WRITEBACK.
  - IDLE, request miss, otherwise → ALLOCATE.
  - WRITEBACK with `mem_ready` → ALLOCATE.
  - ALLOCATE with `mem_ready` → IDLE. At that edge the line gets data = `mem_rdata`, `valid`=1, `dirty`=0 and the new tag.
- `proc_stall` = request active AND (state ≠ IDLE OR miss). The path is combinational.
- Read hit: `proc_rdata` = stored word at the offset, combinationally. In any other cycle `proc_rdata` is 0.
- Write hit: at the clock edge the addressed word is replaced and `dirty` is set; the other 3 words are unchanged.
- Write miss: allocate first, then complete as a write hit in the first IDLE cycle.
- `mem_read` and `mem_write` are decoded from state only and are never high together.
- `proc_read` and `proc_write` both high is illegal. Flag it with an assertion; RTL treats the case as a write.
- Request dropped while in WRITEBACK or ALLOCATE: the memory transaction still completes and the FSM returns to IDLE with no proc-side effect.
- `mem_ready` high in IDLE is ignored.

## Timing
- Reset values:
  - state IDLE; all `valid`/`dirty` bits 0.
  - `mem_read`=`mem_write`=0; `mem_addr`=0; `mem_wdata`=0.
  - `proc_stall`=0 and `proc_rdata`=0 while no request is active.
  - Data and tag arrays are not reset.
- Hit latency is 0 cycles: the request is completed in the cycle it is presented.
- Clean miss, memory answering on the k-th cycle of `mem_read`:
  - `mem_read` is high for cycles 1..k.
  - `proc_stall` is high for cycles 0..k.
  - The hit completes in cycle k+1.
- Dirty miss: add the WRITEBACK duration (j cycles) ahead of ALLOCATE.
- After a `mem_ready` edge the request line drops in the next cycle. There are no back-to-back memory requests without an intervening state change.
- Reset asserted mid-miss:
  - Outstanding requests drop on the next cycle.
  - All lines are invalidated.
  - Dirty data is lost; this is accepted behaviour.
  - Memory must tolerate the aborted request.

## Structure
- Package `l1_cache_pkg`:
  - state enum {IDLE, WRITEBACK, ALLOCATE};
  - `WORDS_PER_BLOCK`=4, `BLOCK_W`=128, `MEM_ADDR_W`=28, `PROC_ADDR_W`=30;
  - a tag-width function of INDEX_W.
- Sub-module `l1_cache_array`: tag/valid/dirty/data storage with one read port and one write port. Write modes are word-write (hit) and line-fill (allocate).
- The FSM and hit logic stay in `l1_cache`.

## Test plan
- Cold read of `proc_addr`=0x00000005, memory ready after 3 cycles with word1=0xDEADBEEF:
  - `mem_read` high for 3 cycles with `mem_addr`=0x0000001;
  - stall high for 4 cycles;
  - `proc_rdata`=0xDEADBEEF on the following cycle.
- Read hit to the same block at 0x00000006: `proc_stall`=0 and the correct word appears in the same cycle.
- Write hit 0x12345678 to 0x00000004, then evict it with a read of 0x00000024 (same index, tag differs):
  - WRITEBACK occurs with `mem_addr`=0x0000001 and `mem_wdata`[31:0]=0x12345678;
  - ALLOCATE follows with `mem_addr`=0x0000009.
- Write miss to a clean line: ALLOCATE, then a hit-write completes. A subsequent read returns the written word and the 3 other fill words.
- Reset asserted during ALLOCATE: `mem_read`=0 the next cycle, and re-reading the old address misses.
- Random ren/wen traffic against a reference memory model:
  - every returned read matches the model;
  - `mem_read` and `mem_write` are never both high.
